nibble_serial_adder: RTL

- Multi-cycle wide adder/subtractor. Each cycle it processes one 4-bit slice: {carry, sum_nibble} = a_nib + b_nib + carry.
- The slice arithmetic is the same 4-bit carry look-ahead addition used elsewhere in the codebase.
- Accepts WIDTH-bit operands on a valid/ready input handshake, walks them LSB nibble first, and presents the assembled result on a valid/ready output handshake.
- Sits between the operand source and downstream result consumers as the sequential wrapper around the 4-bit CLA slice.

---
 rtl/nibble_serial_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder/subtractor: one 4-bit carry look-ahead slice per cycle,
// LSB nibble first, with valid/ready handshakes on operands and result.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [5:0]         w_slice;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    // 4-bit CLA slice; returns {carry out, carry into bit 3, sum nibble}
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    // Operand registers shift right each RUN cycle, so the active nibble is always [3:0]
    assign w_slice = cla4(r_a[3:0], r_b[3:0], r_carry);
    assign w_last  = (r_idx == IDX_W'(NIB - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_idx   <= '0;
                r_res   <= '0;
            end

            // Result nibbles enter from the top; after NIB shifts nibble 0 sits at [3:0]
            if (r_state == S_RUN) begin
                r_a     <= r_a >> 4;
                r_b     <= r_b >> 4;
                r_carry <= w_slice[5];
                r_res   <= {w_slice[3:0], r_res[WIDTH-1:4]};
                if (w_last) begin
                    r_sum  <= {w_slice[3:0], r_res[WIDTH-1:4]};
                    r_cout <= w_slice[5];
                    r_ovf  <= w_slice[5] ^ w_slice[4];
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
